// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcodes and FSM encodings for the multiply/divide unit
//
// Purpose : mdOp encodings and controller state type used by e_mdu and
//           e_mdu_ctrl.
// Ports   : none (package).
// Config  : MADD/MADDU/MSUB/MSUBU are always encoded here; e_mdu only
//           decodes them when E_MDU_MADD_EN is defined.
package mdu_pkg;

   localparam logic [3:0] NONE  = 4'd0;
   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MFHI  = 4'd5;
   localparam logic [3:0] MFLO  = 4'd6;
   localparam logic [3:0] MTHI  = 4'd7;
   localparam logic [3:0] MTLO  = 4'd8;
   localparam logic [3:0] MADD  = 4'd9;
   localparam logic [3:0] MADDU = 4'd10;
   localparam logic [3:0] MSUB  = 4'd11;
   localparam logic [3:0] MSUBU = 4'd12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - run-state FSM and latency counter for the multiply/divide unit
//
// Purpose : Sequences a multiply or divide over a fixed number of cycles and
//           flags the cycle whose closing edge commits the pending result.
// Ports   : clk, reset_n   - clock, asynchronous active-low reset
//           start_mul      - accepted multiply-class operation (IDLE only)
//           start_div      - accepted divide operation (IDLE only)
//           busy           - high in every run-state cycle
//           commit         - high in the last run cycle; hi/lo load on its edge
module e_mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start_mul,
   input  logic start_div,
   output logic busy,
   output logic commit
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] ONE   = CW'(1);

   mdu_state_t     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_mul) begin
               state_d = MUL_RUN;
               cnt_d   = MUL_N;
            end else if (start_div) begin
               state_d = DIV_RUN;
               cnt_d   = DIV_N;
            end
         end
         MUL_RUN, DIV_RUN: begin
            busy  = 1'b1;
            cnt_d = cnt_q - ONE;
            // Counter reaching zero on this edge retires the operation.
            if (cnt_q == ONE) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - EX-stage multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose : Computes MULT/MULTU/DIV/DIVU results at issue, holds them pending
//           for the configured latency, then commits to HI/LO. MTHI/MTLO write
//           in one cycle; MFHI/MFLO read combinationally via mdResult.
// Ports   : clk, reset_n   - clock, asynchronous active-low reset
//           start          - qualifies mdOp this cycle (ignored while busy)
//           mdOp           - operation code (mdu_pkg)
//           srcA, srcB     - rs / rt operands
//           busy           - operation in flight
//           hi, lo         - HI/LO registers
//           mdResult       - hi for MFHI, lo for MFLO, else 0
// Config  : E_MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (multiply latency,
//           accumulate into the hi/lo seen at issue, modulo 2^(2*WIDTH)).
module e_mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       mdOp,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mdResult
);

   logic               accept;
   logic               is_mul, is_div, mul_signed, div_signed;
   logic               commit;
   logic [2*WIDTH-1:0] ext_a, ext_b, product, result;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, uq, ur, quot, rem;
   logic [WIDTH-1:0]   hi_pend, lo_pend;

   assign accept = start & ~busy;

   always_comb begin
      is_mul     = (mdOp == MULT) || (mdOp == MULTU);
      mul_signed = (mdOp == MULT);
`ifdef E_MDU_MADD_EN
      is_mul     = is_mul || (mdOp == MADD) || (mdOp == MADDU) ||
                   (mdOp == MSUB) || (mdOp == MSUBU);
      mul_signed = mul_signed || (mdOp == MADD) || (mdOp == MSUB);
`endif
      is_div     = (mdOp == DIV) || (mdOp == DIVU);
      div_signed = (mdOp == DIV);
   end

   // One 2W-bit multiplier serves both signednesses: extending the operands
   // to 2W bits and keeping the low 2W product bits is exact either way.
   assign ext_a   = {{WIDTH{mul_signed & srcA[WIDTH-1]}}, srcA};
   assign ext_b   = {{WIDTH{mul_signed & srcB[WIDTH-1]}}, srcB};
   assign product = ext_a * ext_b;

   // Signed divide via magnitudes on a single unsigned divider. This also
   // yields lo=srcA, hi=0 for most-negative / -1 without a native signed
   // divide that could overflow.
   assign neg_a = div_signed & srcA[WIDTH-1];
   assign neg_b = div_signed & srcB[WIDTH-1];
   assign mag_a = neg_a ? (~srcA + 1'b1) : srcA;
   assign mag_b = neg_b ? (~srcB + 1'b1) : srcB;
   assign uq    = mag_a / mag_b;
   assign ur    = mag_a % mag_b;
   assign quot  = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
   assign rem   = neg_a ? (~ur + 1'b1) : ur;

   always_comb begin
      result = product;
      if (is_div) begin
         if (srcB == '0) result = {srcA, {WIDTH{1'b1}}};
         else            result = {rem, quot};
      end
`ifdef E_MDU_MADD_EN
      if ((mdOp == MADD) || (mdOp == MADDU)) result = {hi, lo} + product;
      if ((mdOp == MSUB) || (mdOp == MSUBU)) result = {hi, lo} - product;
`endif
   end

   e_mdu_ctrl #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_ctrl (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_mul (accept & is_mul),
      .start_div (accept & is_div),
      .busy      (busy),
      .commit    (commit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi      <= '0;
         lo      <= '0;
         hi_pend <= '0;
         lo_pend <= '0;
      end else begin
         if (accept && (is_mul || is_div)) begin
            hi_pend <= result[2*WIDTH-1:WIDTH];
            lo_pend <= result[WIDTH-1:0];
         end
         // commit only occurs while busy, so it never collides with MTHI/MTLO.
         if (commit) begin
            hi <= hi_pend;
            lo <= lo_pend;
         end else if (accept && (mdOp == MTHI)) begin
            hi <= srcA;
         end else if (accept && (mdOp == MTLO)) begin
            lo <= srcA;
         end
      end
   end

   always_comb begin
      mdResult = '0;
      if (mdOp == MFHI)      mdResult = hi;
      else if (mdOp == MFLO) mdResult = lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu (E_MDU_MADD_EN optional)
module tb_e_mdu;
   import mdu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    mdOp = NONE;
   logic [W-1:0]  srcA = '0;
   logic [W-1:0]  srcB = '0;
   logic          busy;
   logic [W-1:0]  hi, lo, mdResult;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cycles;
   } exp_t;

   exp_t sb[$];

   e_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .mdOp     (mdOp),
      .srcA     (srcA),
      .srcB     (srcB),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .mdResult (mdResult)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Drive one start cycle; returns just after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; mdOp = op; srcA = a; srcB = b;
      @(posedge clk);
      #1;
      start = 1'b0; mdOp = NONE; srcA = '0; srcB = '0;
   endtask

   // Count busy cycles until busy drops (bounded), then compare to scoreboard.
   task automatic wait_done(input int already);
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = already;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check({e.tag, "_cycles"}, W'(n), W'(e.cycles));
      check({e.tag, "_busy"}, W'(busy), W'(0));
      check({e.tag, "_hi"}, hi, e.hi);
      check({e.tag, "_lo"}, lo, e.lo);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", W'(busy), W'(0));
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      reset_n = 1'b1;

      // Signed multiply -2 * 3
      sb.push_back('{"mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
      issue(MULT, 32'hFFFF_FFFE, 32'd3);
      wait_done(0);

      // Unsigned max * max
      sb.push_back('{"multu", 32'hFFFF_FFFE, 32'h0000_0001, 5});
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0);

      // Signed divide truncates toward zero: -7 / 2
      sb.push_back('{"div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
      issue(DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(0);

      // Divide by zero
      sb.push_back('{"divu0", 32'h1234_5678, 32'hFFFF_FFFF, 10});
      issue(DIVU, 32'h1234_5678, 32'd0);
      wait_done(0);

      // Signed overflow
      sb.push_back('{"divovf", 32'h0000_0000, 32'h8000_0000, 10});
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0);

      // Unsigned divide with remainder
      sb.push_back('{"divu", 32'd2, 32'd14, 10});
      issue(DIVU, 32'd100, 32'd7);
      wait_done(0);

      // MTLO while busy is dropped; multiply result lands
      sb.push_back('{"mtlo_busy", 32'h0, 32'h2A, 5});
      issue(MULT, 32'd7, 32'd6);
      @(negedge clk);
      check("mtlo_busy_inflight", W'(busy), W'(1));
      start = 1'b1; mdOp = MTLO; srcA = 32'hABCD;
      @(posedge clk);
      #1;
      start = 1'b0; mdOp = NONE; srcA = '0;
      wait_done(1);

      // MTHI when idle, then combinational reads
      issue(MTHI, 32'h55, 32'h0);
      @(negedge clk);
      check("mthi_busy", W'(busy), W'(0));
      check("mthi_hi", hi, 32'h55);
      check("mthi_lo", lo, 32'h2A);
      mdOp = MFHI; #1;
      check("mfhi", mdResult, 32'h55);
      mdOp = MFLO; #1;
      check("mflo", mdResult, 32'h2A);
      mdOp = NONE; #1;
      check("mdres_none", mdResult, '0);

      // Undefined opcode is a no-op
      issue(4'd13, 32'hDEAD_BEEF, 32'h1);
      @(negedge clk);
      check("undef_busy", W'(busy), W'(0));
      check("undef_hi", hi, 32'h55);
      check("undef_lo", lo, 32'h2A);

      // Reset mid-divide aborts and clears everything
      issue(DIV, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      check("abort_inflight", W'(busy), W'(1));
      reset_n = 1'b0;
      #1;
      check("abort_busy", W'(busy), W'(0));
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_after_busy", W'(busy), W'(0));
      check("abort_after_hi", hi, '0);
      check("abort_after_lo", lo, '0);

`ifdef E_MDU_MADD_EN
      issue(MTLO, 32'hFFFF_FFFF, 32'h0);
      sb.push_back('{"maddu", 32'h1, 32'h0, 5});
      issue(MADDU, 32'd1, 32'd1);
      wait_done(0);
      // {1,0} - 2*3
      sb.push_back('{"msub", 32'h0, 32'hFFFF_FFFA, 5});
      issue(MSUB, 32'd2, 32'd3);
      wait_done(0);
`else
      issue(MTLO, 32'hFFFF_FFFF, 32'h0);
      issue(MADDU, 32'd1, 32'd1);
      @(negedge clk);
      check("maddu_off_busy", W'(busy), W'(0));
      check("maddu_off_hi", hi, '0);
      check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit in the EX stage, beside e_alu.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over a configurable latency.
- Exposes busy so hazard control stalls any MD instruction issued while an operation is in flight.
- Serves MFHI/MFLO/MTHI/MTLO in a single cycle.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits.
- MULT_CYCLES, 5: busy cycles for a multiply; must be ≥1.
- DIV_CYCLES, 10: busy cycles for a divide; must be ≥1.

Ports:
- clk  in  1  single clock; all registers on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  qualifies mdOp for an operation this cycle.
- mdOp  in  4  operation code; encodings defined in the package.
- srcA  in  WIDTH  rs value.
- srcB  in  WIDTH  rt value.
- busy  out  1  high while a multiply/divide is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mdResult  out  WIDTH  combinational: hi when mdOp=MFHI, lo when mdOp=MFLO, else 0.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending results=0.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE, start=1, mdOp=MULT/MULTU:
  - latch {hi_next, lo_next} = full 2*WIDTH product, signed or unsigned;
  - counter=MULT_CYCLES; state goes to MUL_RUN.
- IDLE, start=1, mdOp=DIV/DIVU: latch lo_next=quotient, hi_next=remainder (signed divide truncates toward zero; remainder takes the sign of the dividend); counter=DIV_CYCLES; state goes to DIV_RUN.
- busy=1 in every cycle the state is MUL_RUN or DIV_RUN, i.e. exactly N cycles starting the cycle after start.
- Counter decrements each cycle in a run state. On the edge where counter goes 1 to 0: hi<=hi_next, lo<=lo_next, state goes to IDLE.
- Updated hi/lo are visible in the first cycle busy=0.
- IDLE, start=1, mdOp=MTHI: hi<=srcA next edge, lo unchanged. MTLO likewise for lo. No busy cycles.
- MFHI/MFLO: purely combinational read; no state change; start is ignored.
- start=1 while busy=1: ignored, including MTHI/MTLO. Upstream must stall on (busy | start & isMD); the unit never queues.
- Divide by zero (srcB=0): completes with normal DIV_CYCLES latency; lo=all ones, hi=srcA.
- Signed overflow (DIV, srcA=most-negative, srcB=-1): lo=srcA, hi=0.
- Undefined mdOp with start=1: no-op.
- reset_n low mid-operation: operation aborted, all state to reset values, hi/lo not updated.

Optional Feature:
- Macro: E_MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU opcodes.
  - Uses MULT_CYCLES latency.
  - Final {hi,lo} = {hi,lo} ± product, computed from the hi/lo values at start.
  - Modulo 2^(2*WIDTH) wrap.
- Undefined: those opcodes decode as undefined, i.e. no-op.

Decomposition:
- Package mdu_pkg holds:
  - mdOp localparams: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12;
  - FSM state encodings (IDLE=0, MUL_RUN=1, DIV_RUN=2).
- One natural sub-module: e_mdu_ctrl, containing the FSM and latency counter, producing busy and the commit strobe.
- Datapath and HI/LO registers stay in e_mdu.

Test Plan:
- MULT, srcA=0xFFFFFFFE (-2), srcB=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> after 5 cycles: hi=0xFFFFFFFE, lo=0x00000001.
- DIV, srcA=-7, srcB=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU srcB=0, srcA=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0xABCD during busy -> ignored, lo holds the multiply result. MTHI 0x55 when idle -> hi=0x55 next cycle; MFHI gives mdResult=0x55 combinationally.
- Start DIV, drop reset_n at cycle 4 -> busy=0, hi=lo=0 immediately. With E_MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0.
